// File: rtl/period_meter_pkg.sv
// Shared types and helpers for the period meter: FSM state encoding and
// the counter-width calculation used by the top level, interface and bench.
package period_meter_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    // Counter width able to hold every value from 0 up to max_count.
    function automatic int cw_of(input int max_count);
        return $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/period_meter_if.sv
// Signal bundle for the period meter: the measured input and the
// measurement results. The master side is the meter itself, the slave
// side is whoever drives x and consumes the measurements.
interface period_meter_if #(
    parameter int CW = 10
);
    logic          x;
    logic [CW-1:0] period_cycles;
    logic [CW-1:0] high_cycles;
    logic          valid;
    logic          timeout;
    logic          measuring;

    modport master (
        input  x,
        output period_cycles,
        output high_cycles,
        output valid,
        output timeout,
        output measuring
    );

    modport slave (
        output x,
        input  period_cycles,
        input  high_cycles,
        input  valid,
        input  timeout,
        input  measuring
    );
endinterface

// File: rtl/period_meter_edge_sync.sv
// Brings an asynchronous input into the clk domain and produces registered
// one-cycle rise/fall pulses. Both edges see the same pipeline depth, so the
// spacing between detected edges equals the spacing of the original edges.
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic x,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_chain;
    logic                   xs;
    logic                   xs_d;

    assign xs = sync_chain[SYNC_STAGES-1];

    // Synchroniser chain, one-cycle delay flop and registered edge pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_chain <= '0;
            xs_d       <= 1'b0;
            rise       <= 1'b0;
            fall       <= 1'b0;
        end else begin
            sync_chain <= {sync_chain[SYNC_STAGES-2:0], x};
            xs_d       <= xs;
            rise       <= xs & ~xs_d;
            fall       <= ~xs & xs_d;
        end
    end

endmodule

// File: rtl/period_meter.sv
// Measures the period and high-time of a slow input in clk cycles. A rise
// starts a measurement; each subsequent rise closes one period and strobes
// valid. If no rise arrives by MAX_COUNT cycles the measurement is abandoned
// and the sticky timeout flag is raised until the next good measurement.
module period_meter
    import period_meter_pkg::*;
#(
    parameter int MAX_COUNT   = 1023,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            reset,
    period_meter_if.master  bus
);

    localparam int CW = cw_of(MAX_COUNT);

    logic          rise;
    logic          fall;
    state_t        state;
    logic [CW-1:0] counter;
    logic [CW-1:0] high_next;
    logic [CW-1:0] period_reg;
    logic [CW-1:0] high_reg;
    logic          valid_reg;
    logic          timeout_reg;
    logic          measuring_reg;

    edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
        .clk   (clk),
        .reset (reset),
        .x     (bus.x),
        .rise  (rise),
        .fall  (fall)
    );

    // Measurement FSM with its cycle counter and registered outputs; the
    // saturation test comes before the increment so the counter never wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            counter       <= '0;
            high_next     <= '0;
            period_reg    <= '0;
            high_reg      <= '0;
            valid_reg     <= 1'b0;
            timeout_reg   <= 1'b0;
            measuring_reg <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        counter       <= CW'(1);
                        state         <= MEASURE;
                        measuring_reg <= 1'b1;
                    end
                end
                MEASURE: begin
                    if (fall) begin
                        high_next <= counter;
                    end
                    if (rise) begin
                        period_reg  <= counter;
                        high_reg    <= high_next;
                        valid_reg   <= 1'b1;
                        timeout_reg <= 1'b0;
                        counter     <= CW'(1);
                    end else if (counter == CW'(MAX_COUNT)) begin
                        timeout_reg   <= 1'b1;
                        state         <= IDLE;
                        measuring_reg <= 1'b0;
                        counter       <= '0;
                    end else begin
                        counter <= counter + CW'(1);
                    end
                end
                default: begin
                    state         <= IDLE;
                    measuring_reg <= 1'b0;
                    counter       <= '0;
                end
            endcase
        end
    end

    assign bus.period_cycles = period_reg;
    assign bus.high_cycles   = high_reg;
    assign bus.valid         = valid_reg;
    assign bus.timeout       = timeout_reg;
    assign bus.measuring     = measuring_reg;

endmodule

// File: tb/tb_period_meter.sv
// Bench for period_meter: drives x one clk cycle at a time and predicts the
// outputs from the x waveform itself (times of rising and falling edges),
// then checks every output on every cycle after the fixed detection latency.
module tb_period_meter;
    import period_meter_pkg::*;

    localparam int MAX_COUNT   = 15;
    localparam int SYNC_STAGES = 2;
    localparam int CW          = cw_of(MAX_COUNT);
    localparam int LAT         = SYNC_STAGES + 1;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    period_meter_if #(.CW(CW)) bus ();

    period_meter #(
        .MAX_COUNT   (MAX_COUNT),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic          valid;
        logic [CW-1:0] period;
        logic [CW-1:0] high;
        logic          timeout;
        logic          measuring;
    } snap_t;

    snap_t pipe[$];
    snap_t cur;
    int    t;
    int    rise_t;
    int    high_next_m;
    bit    armed;
    bit    prev_x;

    int checks_total  = 0;
    int checks_passed = 0;

    task automatic check_field(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checks_total++;
        assert (observed === expected) checks_passed++;
        else $error("FAIL %s at t=%0t observed=%0d expected=%0d", tag, $time, observed, expected);
    endtask

    task automatic check_outputs(input snap_t e);
        check_field("valid",         16'(bus.valid),         16'(e.valid));
        check_field("period_cycles", 16'(bus.period_cycles), 16'(e.period));
        check_field("high_cycles",   16'(bus.high_cycles),   16'(e.high));
        check_field("timeout",       16'(bus.timeout),       16'(e.timeout));
        check_field("measuring",     16'(bus.measuring),     16'(e.measuring));
    endtask

    task automatic model_reset();
        t           = 0;
        rise_t      = 0;
        high_next_m = 0;
        armed       = 1'b0;
        prev_x      = 1'b0;
        cur         = '0;
    endtask

    // Predicted outputs from the x waveform: periods are differences of rise
    // times, high-times are fall time minus rise time, and a measurement is
    // abandoned once MAX_COUNT cycles pass after a rise with no new rise.
    task automatic model_step(input bit xv);
        t++;
        cur.valid = 1'b0;
        if (xv && !prev_x) begin
            if (armed) begin
                cur.valid   = 1'b1;
                cur.period  = CW'(t - rise_t);
                cur.high    = CW'(high_next_m);
                cur.timeout = 1'b0;
            end
            armed  = 1'b1;
            rise_t = t;
        end else if (armed) begin
            if (!xv && prev_x) high_next_m = t - rise_t;
            if (t - rise_t == MAX_COUNT) begin
                cur.timeout = 1'b1;
                armed       = 1'b0;
            end
        end
        cur.measuring = armed;
        prev_x        = xv;
    endtask

    task automatic step(input bit xv, input bit rst);
        snap_t expected;
        bus.x = xv;
        reset = rst;
        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
            check_outputs('0);
            pipe.delete();
            repeat (LAT) pipe.push_back('0);
        end else begin
            model_step(xv);
            pipe.push_back(cur);
            expected = pipe.pop_front();
            check_outputs(expected);
        end
    endtask

    task automatic wave(input int hi, input int lo, input int reps);
        for (int r = 0; r < reps; r++) begin
            repeat (hi) step(1'b1, 1'b0);
            repeat (lo) step(1'b0, 1'b0);
        end
    endtask

    initial begin
        bus.x = 1'b0;
        reset = 1'b1;
        model_reset();

        repeat (3) step(1'b0, 1'b1);
        repeat (4) step(1'b0, 1'b0);

        // Divider-style square wave, period 10 / high 5.
        wave(5, 5, 5);
        // Asymmetric wave, period 10 / high 3.
        wave(3, 7, 5);

        // Single rise then held high: timeout, then recovery at period 8.
        repeat (25) step(1'b1, 1'b0);
        repeat (4) step(1'b0, 1'b0);
        wave(4, 4, 5);

        // Longest measurable period, then one cycle too long.
        wave(7, 8, 4);
        wave(8, 8, 3);
        repeat (20) step(1'b0, 1'b0);

        // Reset in the middle of a period-10 measurement, then re-acquire.
        wave(5, 5, 3);
        repeat (3) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        repeat (2) step(1'b1, 1'b0);
        repeat (5) step(1'b0, 1'b0);
        wave(5, 5, 4);

        // One-cycle glitches every 6 cycles.
        wave(1, 5, 6);

        // Random high/low lengths, some long enough to time out.
        for (int i = 0; i < 40; i++) begin
            wave(int'($urandom_range(1, 7)), int'($urandom_range(1, 10)), 1);
        end

        repeat (30) step(1'b0, 1'b0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
